// File: rtl/pc_seq_pkg.sv
// Shared constants, state encoding and address helpers for the fetch-stage PC sequencer.
package pc_seq_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] PC_STEP              = 32'h0000_0004;
    localparam logic [XLEN-1:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [XLEN-1:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0004;

    typedef enum logic [1:0] {
        ST_RESET = 2'b00,
        ST_RUN   = 2'b01,
        ST_REDIR = 2'b10
    } pc_state_e;

    // Redirect targets are word aligned: the two low bits are dropped.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch-control bundle between the PC sequencer and the pipeline/instruction memory.
// Trap signals exist only when PC_SEQ_TRAP_EN is defined.
interface pc_sequencer_if;
    import pc_seq_pkg::*;

    logic            busyWait;
    logic            hazardStall;
    logic            branchTaken;
    logic [XLEN-1:0] branchTarget;
    logic [XLEN-1:0] PC;
    logic            pcValid;
    logic            flush;
    logic            redirectPending;
`ifdef PC_SEQ_TRAP_EN
    logic            trapReq;
    logic [XLEN-1:0] epc;
`endif

    modport master (
`ifdef PC_SEQ_TRAP_EN
        input  trapReq,
        output epc,
`endif
        input  busyWait, hazardStall, branchTaken, branchTarget,
        output PC, pcValid, flush, redirectPending
    );

    modport slave (
`ifdef PC_SEQ_TRAP_EN
        output trapReq,
        input  epc,
`endif
        output busyWait, hazardStall, branchTaken, branchTarget,
        input  PC, pcValid, flush, redirectPending
    );

endinterface

// File: rtl/pc_pending_redirect.sv
// Holds a redirect target that arrived while instruction memory was busy.
module pc_pending_redirect
    import pc_seq_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            clear,
    input  logic [XLEN-1:0] load_target,
    output logic [XLEN-1:0] target,
    output logic            valid
);

    logic [XLEN-1:0] target_r;
    logic            valid_r;

    // Pending target register; a new load overrides a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            target_r <= '0;
            valid_r  <= 1'b0;
        end else if (load) begin
            target_r <= load_target;
            valid_r  <= 1'b1;
        end else if (clear) begin
            valid_r  <= 1'b0;
        end
    end

    assign target = target_r;
    assign valid  = valid_r;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: increment, hold on stalls, branch redirect (deferred while busy).
// Optional trap redirect and EPC capture enabled by PC_SEQ_TRAP_EN.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
`ifdef PC_SEQ_TRAP_EN
   ,parameter logic [XLEN-1:0] TRAP_VECTOR  = DEFAULT_TRAP_VECTOR
`endif
)(
    input  logic CLK,
    input  logic RESET,
    pc_sequencer_if.master bus
);

    pc_state_e       state_r, state_nx_s;
    logic [XLEN-1:0] pc_r, pc_nx_s;
    logic            pc_valid_r;
    logic            flush_r, flush_nx_s;
    logic            redirect_s;
    logic [XLEN-1:0] redir_target_s;
    logic            pend_load_s, pend_clear_s, pend_valid_s;
    logic [XLEN-1:0] pend_target_s;
`ifdef PC_SEQ_TRAP_EN
    logic [XLEN-1:0] epc_r, epc_nx_s;
`endif

    pc_pending_redirect u_pending (
        .clk         (CLK),
        .rst         (RESET),
        .load        (pend_load_s),
        .clear       (pend_clear_s),
        .load_target (redir_target_s),
        .target      (pend_target_s),
        .valid       (pend_valid_s)
    );

    // Next-state, next-PC and flush decision.
    always_comb begin
        state_nx_s     = state_r;
        pc_nx_s        = pc_r;
        flush_nx_s     = 1'b0;
        pend_load_s    = 1'b0;
        pend_clear_s   = 1'b0;
        redirect_s     = bus.branchTaken;
        redir_target_s = align_pc(bus.branchTarget);
`ifdef PC_SEQ_TRAP_EN
        epc_nx_s       = epc_r;
        if (bus.trapReq && (state_r != ST_RESET)) begin
            redirect_s     = 1'b1;
            redir_target_s = TRAP_VECTOR;
            epc_nx_s       = pc_r;
        end else begin
            epc_nx_s       = epc_r;
        end
`endif
        case (state_r)
            ST_RESET: begin
                state_nx_s = ST_RUN;
            end
            ST_RUN: begin
                if (redirect_s) begin
                    flush_nx_s = 1'b1;
                    if (bus.busyWait) begin
                        pend_load_s = 1'b1;
                        state_nx_s  = ST_REDIR;
                    end else begin
                        pc_nx_s     = redir_target_s;
                    end
                end else if (bus.busyWait || bus.hazardStall) begin
                    pc_nx_s = pc_r;
                end else begin
                    pc_nx_s = pc_r + PC_STEP;
                end
            end
            ST_REDIR: begin
                // A fresh redirect supersedes the latched one.
                if (redirect_s) begin
                    flush_nx_s = 1'b1;
                    if (bus.busyWait) begin
                        pend_load_s  = 1'b1;
                    end else begin
                        pc_nx_s      = redir_target_s;
                        pend_clear_s = 1'b1;
                        state_nx_s   = ST_RUN;
                    end
                end else if (bus.busyWait) begin
                    pc_nx_s = pc_r;
                end else begin
                    pc_nx_s      = pend_target_s;
                    pend_clear_s = 1'b1;
                    state_nx_s   = ST_RUN;
                end
            end
            default: begin
                state_nx_s = ST_RESET;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r    <= ST_RESET;
            pc_r       <= RESET_VECTOR;
            pc_valid_r <= 1'b0;
            flush_r    <= 1'b0;
`ifdef PC_SEQ_TRAP_EN
            epc_r      <= '0;
`endif
        end else begin
            state_r    <= state_nx_s;
            pc_r       <= pc_nx_s;
            pc_valid_r <= 1'b1;
            flush_r    <= flush_nx_s;
`ifdef PC_SEQ_TRAP_EN
            epc_r      <= epc_nx_s;
`endif
        end
    end

    assign bus.PC              = pc_r;
    assign bus.pcValid         = pc_valid_r;
    assign bus.flush           = flush_r;
    assign bus.redirectPending = pend_valid_s;
`ifdef PC_SEQ_TRAP_EN
    assign bus.epc             = epc_r;
`endif

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Controller that sequences the fetch-stage program counter of the RISC-V pipeline. It selects the next PC each cycle from sequential increment, branch redirect, or (optionally) trap vector. It holds the PC under instruction-memory and hazard stalls, and latches a redirect that arrives while instruction memory is busy. It drives the IF/ID flush pulse and a fetch-valid qualifier for the instruction memory.

## Interface
- `RESET_VECTOR`, default 32'h0000_0000: PC loaded on reset.
- `TRAP_VECTOR`, default 32'h0000_0004: trap redirect target (used only with `PC_SEQ_TRAP_EN`).
- `CLK`  in  1  single clock; all state updates on posedge.
- `RESET`  in  1  synchronous, active-high reset.
- `busyWait`  in  1  instruction memory not ready; the current fetch must be held.
- `hazardStall`  in  1  hazard unit requests the fetch PC be frozen (load-use).
- `branchTaken`  in  1  EX stage resolved a taken branch/jump this cycle.
- `branchTarget`  in  32  redirect address, valid when `branchTaken`=1.
- `trapReq`  in  1  trap request (present only with `PC_SEQ_TRAP_EN`).
- `PC`  out  32  current fetch address (registered).
- `pcValid`  out  1  `PC` is a live fetch request.
- `flush`  out  1  one-cycle pulse that kills the IF/ID and ID/EX contents.
- `redirectPending`  out  1  a redirect is latched and waiting for `busyWait` to drop.
- `epc`  out  32  PC captured on trap (present only with `PC_SEQ_TRAP_EN`).

## Operation
- States: ST_RESET, ST_RUN, ST_REDIR.
- Reset, while `RESET`=1 at a posedge:
  - `PC`=RESET_VECTOR; `pcValid`=0, `flush`=0, `redirectPending`=0, `epc`=0.
  - State goes to ST_RESET.
- ST_RESET: on the first edge with `RESET`=0, go to ST_RUN and set `pcValid`=1. `PC` keeps RESET_VECTOR, so that address is the first fetch.
- ST_RUN priority, highest first:
  1. Trap (with macro only).
  2. `branchTaken`.
  3. `busyWait` hold.
  4. `hazardStall` hold.
  5. Increment: `PC`<=`PC`+4.
- Redirect in ST_RUN, `busyWait`=0:
  - `PC`<=target with bits [1:0] forced to 00.
  - `flush`=1 for the next cycle; stay in ST_RUN.
- Redirect in ST_RUN, `busyWait`=1:
  - Latch the aligned target in the pending register; `flush`=1 for one cycle.
  - Go to ST_REDIR; `PC` holds.
- ST_REDIR:
  - `redirectPending`=1; `PC` holds regardless of `hazardStall`.
  - On the first edge with `busyWait`=0: `PC`<=pending target, clear pending, go to ST_RUN.
  - A new redirect in ST_REDIR overwrites the pending target and pulses `flush` again.
- A redirect together with `hazardStall` takes the redirect; the stalled instruction is flushed.
- Arithmetic is modulo 2^32: 32'hFFFF_FFFC+4 → 32'h0000_0000, with no error flag.
- `RESET` mid-operation (any state, pending redirect included) applies the full reset values at the next edge. The pending target is discarded.

## Timing
- Increment, redirect and release are all registered: `PC` changes exactly one edge after the qualifying inputs are sampled.
- `flush` is asserted in the cycle after the redirect is sampled, for exactly one cycle.
- Redirect latency, `busyWait`=0: 1 cycle.
- Redirect latency, `busyWait`=1: target appears on `PC` one edge after `busyWait` is first sampled low.
- `pcValid` is low only in reset and ST_RESET. Stalls do not drop it; the memory sees the same address held.
- No combinational path from any input to `PC`, `pcValid`, `flush` or `redirectPending`.

## Configuration
- `PC_SEQ_TRAP_EN` defined:
  - `trapReq` and `epc` ports exist.
  - `trapReq`=1 takes priority over `branchTaken` and redirects to TRAP_VECTOR through the same ST_RUN/ST_REDIR path.
  - `epc`<=`PC` at the sampling edge.
- Not defined: ports are absent, there is no trap logic, and `branchTaken` is the top priority.

## Structure
- Package `pc_seq_pkg`: XLEN=32, PC_STEP=4, the state enum, and default RESET_VECTOR/TRAP_VECTOR constants.
- One sub-module, `pc_pending_redirect`: pending-target register plus valid bit, with load, clear and synchronous reset.

## Test plan
- Reset release: hold `RESET` 2 cycles, then free-run with no stalls → `PC` 0x0, 0x0 (`pcValid` rising), 0x4, 0x8; `flush`=0 throughout.
- `hazardStall` for 2 cycles at `PC`=0x8 → `PC` stays 0x8 for 2 cycles, then 0xC; `pcValid` stays 1.
- `branchTaken` with target 0x103 and `busyWait`=0 at `PC`=0x10 → next `PC`=0x100, `flush`=1 for one cycle.
- `busyWait`=1, `branchTaken` with target 0x200, `busyWait` held 3 more cycles:
  - `redirectPending`=1 and `PC` held during the wait.
  - `PC`=0x200 one edge after `busyWait` drops; single `flush` pulse.
- `PC`=0xFFFF_FFFC, no stall → `PC`=0x0.
- `RESET` during ST_REDIR → `PC`=RESET_VECTOR, `redirectPending`=0. With `PC_SEQ_TRAP_EN`, `trapReq` plus `branchTaken` at `PC`=0x40 → `PC`=0x4, `epc`=0x40.
